// File: rtl/default_port_rx.sv
// Receive side of an 8-bit producer port: buffers bytes in a small FIFO and
// watches for a source that appears stuck at its tie-off default value.
// Latency 1 cycle push-to-out_data; in_ready drops when the FIFO is full.
module default_port_rx #(
    parameter logic [7:0] DEFAULT_VALUE = 8'd123,
    parameter int         DEPTH         = 4,
    parameter int         STUCK_LIMIT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] hit_count,
    output logic        stuck,
    input  logic        clear
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STUCK = 2'd2
    } mon_state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] count_after_pop;
    logic [7:0]    out_data_q;
    logic [7:0]    head_next;
    logic          push;
    logic          pop;

    mon_state_t    state_q;
    mon_state_t    state_d;
    logic [7:0]    run_q;
    logic [7:0]    run_d;
    logic [7:0]    run_inc;
    logic [15:0]   hit_q;
    logic [15:0]   hit_d;
    logic          is_hit;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_data_q;
    assign hit_count = hit_q;
    assign stuck     = (state_q == STUCK);

    // out_data is a register, so the next head is precomputed; when the FIFO
    // is about to drain to zero the incoming byte becomes the head directly.
    always_comb begin
        rd_ptr_next     = rd_ptr + AW'(pop);
        count_after_pop = count - CW'(pop);
        count_next      = count_after_pop + CW'(push);
        head_next       = (count_after_pop == '0) ? in_data : mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_data_q <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            if (count_next != '0) begin
                out_data_q <= head_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            run_q   <= 8'd0;
            hit_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            hit_q   <= hit_d;
        end
    end

    // Monitor only advances on accepted pushes; clear wins over a same-cycle push.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        hit_d   = hit_q;
        is_hit  = (in_data == DEFAULT_VALUE);
        run_inc = run_q + 8'd1;
        if (clear) begin
            state_d = IDLE;
            run_d   = 8'd0;
            hit_d   = 16'd0;
        end else if (push) begin
            if (is_hit && (hit_q != 16'hFFFF)) begin
                hit_d = hit_q + 16'd1;
            end
            case (state_q)
                IDLE, RUN: begin
                    if (is_hit) begin
                        run_d   = run_inc;
                        state_d = (run_inc >= 8'(STUCK_LIMIT)) ? STUCK : RUN;
                    end else begin
                        run_d   = 8'd0;
                        state_d = IDLE;
                    end
                end
                STUCK: begin
                    state_d = STUCK;
                end
                default: begin
                    state_d = IDLE;
                    run_d   = 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_default_port_rx.sv
// Directed bench for default_port_rx: FIFO ordering/full/empty corners and
// the stuck-at-default monitor, with hand-computed expectations.
module tb_default_port_rx;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] hit_count;
    logic        stuck;
    logic        clear;

    int vectors;
    int miscompares;

    default_port_rx #(
        .DEFAULT_VALUE(8'd123),
        .DEPTH(4),
        .STUCK_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .hit_count(hit_count),
        .stuck(stuck),
        .clear(clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 8'd123; out_ready = 1'b0; clear = 1'b0;
        repeat (3) step();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_during: in_ready=%b out_valid=%b out_data=%0d want 1 0 0", in_ready, out_valid, out_data);
        end
        vectors++;
        if (hit_count !== 16'd0 || stuck !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mon: hit_count=%0d stuck=%b want 0 0", hit_count, stuck);
        end
        rst = 1'b1; in_valid = 1'b0;
        step();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || hit_count !== 16'd0 || stuck !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_after: in_ready=%b out_valid=%b hit=%0d stuck=%b want 1 0 0 0", in_ready, out_valid, hit_count, stuck);
        end
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'd1;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd1) begin
            miscompares++;
            $display("FAIL latency: out_valid=%b out_data=%0d want 1 1", out_valid, out_data);
        end
        for (int i = 2; i <= 4; i++) begin
            in_data = 8'(i);
            step();
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready: in_ready=%b want 0", in_ready);
        end
        in_data = 8'd5;
        step();
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || out_data !== 8'd1) begin
            miscompares++;
            $display("FAIL full_refuse: in_ready=%b out_data=%0d want 0 1", in_ready, out_data);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                miscompares++;
                $display("FAIL drain_order: out_valid=%b out_data=%0d want 1 %0d", out_valid, out_data, i);
            end
            step();
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'd4 || hit_count !== 16'd0) begin
            miscompares++;
            $display("FAIL empty_hold: out_valid=%b out_data=%0d hit=%0d want 0 4 0", out_valid, out_data, hit_count);
        end
    endtask

    task automatic test_empty_push_pop();
        in_valid = 1'b1; in_data = 8'd42; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd42) begin
            miscompares++;
            $display("FAIL empty_pushpop: out_valid=%b out_data=%0d want 1 42", out_valid, out_data);
        end
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_pushpop_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 10; i <= 13; i++) begin
            in_data = 8'(i);
            step();
        end
        in_data = 8'd14; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'd11) begin
            miscompares++;
            $display("FAIL full_pushpop: in_ready=%b out_valid=%b out_data=%0d want 1 1 11", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int i = 11; i <= 13; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                miscompares++;
                $display("FAIL full_pushpop_drain: out_valid=%b out_data=%0d want 1 %0d", out_valid, out_data, i);
            end
            step();
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'd13) begin
            miscompares++;
            $display("FAIL full_pushpop_occ: out_valid=%b out_data=%0d want 0 13", out_valid, out_data);
        end
    endtask

    task automatic test_stuck();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd123;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 6) begin
                vectors++;
                if (stuck !== 1'b0 || hit_count !== 16'd7) begin
                    miscompares++;
                    $display("FAIL stuck_early: stuck=%b hit=%0d want 0 7", stuck, hit_count);
                end
            end
        end
        vectors++;
        if (stuck !== 1'b1 || hit_count !== 16'd8) begin
            miscompares++;
            $display("FAIL stuck_set: stuck=%b hit=%0d want 1 8", stuck, hit_count);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (stuck !== 1'b1 || hit_count !== 16'd9) begin
            miscompares++;
            $display("FAIL stuck_hold: stuck=%b hit=%0d want 1 9", stuck, hit_count);
        end
        repeat (2) step();
        out_ready = 1'b0;
    endtask

    task automatic test_run_break();
        clear = 1'b1;
        step();
        clear = 1'b0;
        vectors++;
        if (stuck !== 1'b0 || hit_count !== 16'd0) begin
            miscompares++;
            $display("FAIL clear_idle: stuck=%b hit=%0d want 0 0", stuck, hit_count);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd123;
        repeat (7) step();
        in_data = 8'd5;
        step();
        in_data = 8'd123;
        step();
        vectors++;
        if (stuck !== 1'b0 || hit_count !== 16'd8) begin
            miscompares++;
            $display("FAIL run_break: stuck=%b hit=%0d want 0 8", stuck, hit_count);
        end
        // run restarted at 1: six more hits leave it at 7, the seventh trips stuck
        repeat (6) step();
        vectors++;
        if (stuck !== 1'b0 || hit_count !== 16'd14) begin
            miscompares++;
            $display("FAIL run_restart: stuck=%b hit=%0d want 0 14", stuck, hit_count);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (stuck !== 1'b1 || hit_count !== 16'd15) begin
            miscompares++;
            $display("FAIL run_restart_trip: stuck=%b hit=%0d want 1 15", stuck, hit_count);
        end
        repeat (2) step();
        out_ready = 1'b0;
    endtask

    task automatic test_clear_push();
        vectors++;
        if (stuck !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_pre: stuck=%b out_valid=%b want 1 0", stuck, out_valid);
        end
        in_valid = 1'b1; in_data = 8'd123; clear = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; clear = 1'b0;
        vectors++;
        if (hit_count !== 16'd0 || stuck !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd123) begin
            miscompares++;
            $display("FAIL clear_push: hit=%0d stuck=%b out_valid=%b out_data=%0d want 0 0 1 123",
                     hit_count, stuck, out_valid, out_data);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_data = 8'd1;
        step();
        in_data = 8'd2;
        step();
        rst = 1'b0; in_data = 8'd9;
        step();
        rst = 1'b1; in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'd0 || hit_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b out_data=%0d hit=%0d want 0 1 0 0",
                     out_valid, in_ready, out_data, hit_count);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0; in_data = 8'd0; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        test_reset();
        test_fill_drain();
        test_empty_push_pop();
        test_full_push_pop();
        test_stuck();
        test_run_break();
        test_clear_push();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
